// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle control FSM for a MIPS-subset core.
// Sequences FETCH/DECODE/EXEC/MEM/WB, owns the PC and the retired-instruction
// counter, and drives the memory handshake, IR/regfile write strobes and the
// writeback select.
//
// Ports:
//   clk, rst                   clock, async active-high reset
//   run                        execute enable (sampled in IDLE and at retire)
//   opcode, funct              instruction fields from IR
//   br_taken, br_addr          branch decision and target from the datapath
//   jmp_addr                   J/JAL/JR target from the datapath
//   mem_ready                  memory completes the current request
//   mem_req, mem_we, mem_ifetch memory request, store, instruction-fetch
//   ir_we, reg_we              IR load, regfile write enable
//   wb_sel, wb_rt              writeback source (0 ALU, 1 mem, 2 PC+8), dest is rt
//   pc, state, instr_cnt, err  status
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | waiting for run
// FETCH | instruction read in flight
// DECODE| classify opcode/funct
// EXEC  | branch/jump resolve, route to MEM or WB
// MEM   | data read/write in flight
// WB    | one-cycle regfile write
// ERROR | illegal opcode or memory timeout; exit via rst only

module mc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned WAIT_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        br_taken,
    input  logic [31:0] br_addr,
    input  logic [31:0] jmp_addr,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_ifetch,
    output logic        ir_we,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        wb_rt,
    output logic [31:0] pc,
    output logic [2:0]  state,
    output logic [31:0] instr_cnt,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERROR  = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_BR, C_JMP, C_LINK, C_BAD
    } cls_t;

    localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    state_t          state_q, state_nxt;
    cls_t            cls_q, dec_cls;
    logic [WW-1:0]   wait_cnt;
    logic            retire;
    logic            timeout;
    logic [31:0]     pc_nxt;

    function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
        cls_t c;
        c = C_BAD;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07:
                        c = C_ALU_R;
                    6'h08:   c = C_JMP;
                    default: c = C_BAD;
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: c = C_ALU_I;
            6'h23:   c = C_LOAD;
            6'h2B:   c = C_STORE;
            6'h04, 6'h05, 6'h06: c = C_BR;
            6'h02:   c = C_JMP;
            6'h03:   c = C_LINK;
            default: c = C_BAD;
        endcase
        return c;
    endfunction

    always_comb begin
        state_nxt = state_q;
        retire    = 1'b0;
        dec_cls   = classify(opcode, funct);
        // Fires on the WAIT_MAX-th consecutive non-ready cycle.
        timeout   = (WAIT_MAX != 0) && (wait_cnt == WW'(WAIT_MAX - 1));
        case (state_q)
            S_IDLE:   if (run) state_nxt = S_FETCH;
            S_FETCH: begin
                if (mem_ready)    state_nxt = S_DECODE;
                else if (timeout) state_nxt = S_ERROR;
            end
            S_DECODE: state_nxt = (dec_cls == C_BAD) ? S_ERROR : S_EXEC;
            S_EXEC: begin
                case (cls_q)
                    C_ALU_R, C_ALU_I, C_LINK: state_nxt = S_WB;
                    C_LOAD, C_STORE:          state_nxt = S_MEM;
                    default:                  retire = 1'b1;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (cls_q == C_LOAD) state_nxt = S_WB;
                    else                 retire = 1'b1;
                end else if (timeout) begin
                    state_nxt = S_ERROR;
                end
            end
            S_WB:     retire = 1'b1;
            default:  state_nxt = S_ERROR;
        endcase
        if (retire) state_nxt = run ? S_FETCH : S_IDLE;

        if (cls_q == C_JMP || cls_q == C_LINK) pc_nxt = jmp_addr;
        else if (cls_q == C_BR && br_taken)    pc_nxt = br_addr;
        else                                   pc_nxt = pc + 32'd4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cls_q      <= C_BAD;
            pc         <= RESET_PC;
            instr_cnt  <= 32'd0;
            wait_cnt   <= '0;
            err        <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_ifetch <= 1'b0;
            reg_we     <= 1'b0;
            wb_sel     <= 2'd0;
            wb_rt      <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (state_q == S_DECODE) cls_q <= dec_cls;
            if (retire) begin
                pc        <= pc_nxt;
                instr_cnt <= instr_cnt + 32'd1;
            end
            // Staying in FETCH/MEM means mem_ready was low; any entry clears.
            if ((state_q == S_FETCH || state_q == S_MEM) && state_nxt == state_q)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            err        <= err | (state_nxt == S_ERROR);
            mem_req    <= (state_nxt == S_FETCH) || (state_nxt == S_MEM);
            mem_ifetch <= (state_nxt == S_FETCH);
            mem_we     <= (state_nxt == S_MEM) && (cls_q == C_STORE);
            reg_we     <= (state_nxt == S_WB);
            wb_rt      <= (state_nxt == S_WB) && (cls_q == C_ALU_I || cls_q == C_LOAD);
            if (state_nxt == S_WB)
                wb_sel <= (cls_q == C_LOAD) ? 2'd1 : (cls_q == C_LINK) ? 2'd2 : 2'd0;
            else
                wb_sel <= 2'd0;
        end
    end

    assign state = state_q;
    // Depends on mem_ready in the same cycle, so it cannot be registered.
    assign ir_we = (state_q == S_FETCH) && mem_ready;

endmodule

// File: tb/tb_mc_sequencer.sv
module tb_mc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        br_taken;
    logic [31:0] br_addr;
    logic [31:0] jmp_addr;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_ifetch, ir_we, reg_we, wb_rt, err;
    logic [1:0]  wb_sel;
    logic [31:0] pc, instr_cnt;
    logic [2:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    mc_sequencer #(.RESET_PC(32'h0), .WAIT_MAX(8)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct),
        .br_taken(br_taken), .br_addr(br_addr), .jmp_addr(jmp_addr),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_ifetch(mem_ifetch), .ir_we(ir_we), .reg_we(reg_we),
        .wb_sel(wb_sel), .wb_rt(wb_rt), .pc(pc), .state(state),
        .instr_cnt(instr_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; opcode = 6'h0; funct = 6'h21;
        br_taken = 1'b0; br_addr = 32'h0; jmp_addr = 32'h0; mem_ready = 1'b1;
        step(2);
        check("rst_state", 32'(state), 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_cnt", instr_cnt, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        rst = 1'b0;
        step(1);
        check("idle_hold", 32'(state), 32'd0);

        // ADDU
        run = 1'b1;
        step(1);
        check("addu_fetch", 32'(state), 32'd1);
        check("addu_req", {mem_req, mem_ifetch, ir_we}, 32'b111);
        step(1); check("addu_dec", 32'(state), 32'd2);
        step(1); check("addu_exec", 32'(state), 32'd3);
        check("addu_exec_we", 32'(reg_we), 32'd0);
        step(1); check("addu_wb", 32'(state), 32'd5);
        check("addu_wb_strb", {reg_we, wb_sel, wb_rt}, 32'b1000);
        step(1); check("addu_pc", pc, 32'h4);
        check("addu_cnt", instr_cnt, 32'd1);
        check("addu_we_drop", 32'(reg_we), 32'd0);

        // LW with three wait cycles in MEM
        opcode = 6'h23;
        step(1); mem_ready = 1'b0;
        step(1); check("lw_exec", 32'(state), 32'd3);
        step(1); check("lw_mem1", {state, mem_req, mem_we, mem_ifetch}, {3'd4, 3'b100});
        step(1); check("lw_mem2", {state, mem_req}, {3'd4, 1'b1});
        step(1); check("lw_mem3", {state, mem_req}, {3'd4, 1'b1});
        mem_ready = 1'b1;
        check("lw_mem4", {state, mem_req}, {3'd4, 1'b1});
        step(1); check("lw_wb", {state, reg_we, wb_sel, wb_rt}, {3'd5, 4'b1011});
        step(1); check("lw_pc", pc, 32'h8);
        check("lw_cnt", instr_cnt, 32'd2);

        // BEQ taken, then not taken
        opcode = 6'h04; br_taken = 1'b1; br_addr = 32'h40;
        step(2); check("beq_exec_we", {32'(state), 32'(reg_we)}, {32'd3, 32'd0});
        step(1); check("beq_t_pc", pc, 32'h40);
        check("beq_t_state", 32'(state), 32'd1);
        br_taken = 1'b0;
        step(3); check("beq_nt_pc", pc, 32'h44);
        check("beq_nt_cnt", instr_cnt, 32'd4);

        // J to 0x10, JAL to 0x200, JR to 0x14
        opcode = 6'h02; jmp_addr = 32'h10;
        step(3); check("j_pc", pc, 32'h10);
        opcode = 6'h03; jmp_addr = 32'h200;
        step(3); check("jal_wb", {state, reg_we, wb_sel, wb_rt}, {3'd5, 4'b1100});
        check("jal_pc_hold", pc, 32'h10);
        step(1); check("jal_pc", pc, 32'h200);
        opcode = 6'h00; funct = 6'h08; jmp_addr = 32'h14;
        step(3); check("jr_pc", pc, 32'h14);
        check("jr_cnt", instr_cnt, 32'd7);

        // ADDI
        opcode = 6'h08;
        step(3); check("addi_wb", {state, reg_we, wb_sel, wb_rt}, {3'd5, 4'b1001});
        step(1); check("addi_pc", pc, 32'h18);

        // SW with run dropped mid-instruction
        opcode = 6'h2B;
        step(1); run = 1'b0;
        step(2); check("sw_mem", {state, mem_req, mem_we, mem_ifetch}, {3'd4, 3'b110});
        step(1); check("sw_idle", 32'(state), 32'd0);
        check("sw_we_drop", 32'(mem_we), 32'd0);
        check("sw_pc", pc, 32'h1C);
        check("sw_cnt", instr_cnt, 32'd9);
        step(1); check("sw_idle_hold", 32'(state), 32'd0);

        // LW interrupted by async reset in WB
        run = 1'b1; opcode = 6'h23;
        step(5); check("lw2_wb", {32'(state), 32'(reg_we)}, {32'd5, 32'd1});
        #2; rst = 1'b1; #1;
        check("rst_wb_state", {state, reg_we, mem_req}, {3'd0, 2'b00});
        check("rst_wb_pc", pc, 32'h0);
        check("rst_wb_cnt", instr_cnt, 32'd0);
        step(1); rst = 1'b0;

        // Illegal opcode
        opcode = 6'h3F;
        step(3); check("ill_state", {state, err, mem_req}, {3'd7, 2'b10});
        step(3); check("ill_frozen", {state, err}, {3'd7, 1'b1});
        check("ill_pc", pc, 32'h0);
        check("ill_cnt", instr_cnt, 32'd0);

        // Fetch ready on the 8th cycle is still accepted
        do_reset();
        mem_ready = 1'b0; opcode = 6'h21;
        step(1); check("to_fetch", 32'(state), 32'd1);
        step(7); check("to_7wait", {32'(state), 32'(err)}, {32'd1, 32'd0});
        mem_ready = 1'b1;
        step(1); check("to_late_ok", 32'(state), 32'd2);

        // Eight non-ready fetch cycles -> ERROR
        do_reset();
        mem_ready = 1'b0;
        step(1); check("to2_fetch", 32'(state), 32'd1);
        step(7); check("to2_7wait", 32'(state), 32'd1);
        step(1); check("to2_error", {state, err, mem_req}, {3'd7, 2'b10});
        mem_ready = 1'b1;
        step(2); check("to2_stuck", 32'(state), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
